// File: rtl/mux_scan_if.sv
// Handshake and mux-facing bus between the scan sequencer and its controller/multiplexer.
// The parity signal exists only when SCAN_PARITY_EN is defined.
interface mux_scan_if;
    logic       start;
    logic       abort;
    logic       mux_op;
    logic [2:0] sel;
    logic       busy;
    logic       done;
    logic [7:0] word;
`ifdef SCAN_PARITY_EN
    logic       parity;

    modport master (input start, abort, mux_op, output sel, busy, done, word, parity);
    modport slave  (output start, abort, mux_op, input sel, busy, done, word, parity);
`else
    modport master (input start, abort, mux_op, output sel, busy, done, word);
    modport slave  (output start, abort, mux_op, input sel, busy, done, word);
`endif
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps an 8:1 mux select through channels 0..7, samples after SETTLE cycles each, emits a word.
// Optional SCAN_PARITY_EN adds a registered XOR parity of each completed word.
module mux_scan_sequencer #(
    parameter int unsigned SETTLE = 1
) (
    input logic       clk,
    input logic       rst,
    mux_scan_if.master bus
);
    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);
    // With zero settle time every channel goes straight to its sampling cycle.
    localparam state_t CH_FIRST = (SETTLE == 0) ? SAMPLE : WAIT;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [6:0] shadow, shadow_nxt;
    logic [2:0] sel_nxt;
    logic       busy_nxt, done_nxt;
    logic [7:0] word_nxt;
`ifdef SCAN_PARITY_EN
    logic       parity_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            shadow   <= '0;
            bus.sel  <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.word <= 8'h00;
`ifdef SCAN_PARITY_EN
            bus.parity <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            shadow   <= shadow_nxt;
            bus.sel  <= sel_nxt;
            bus.busy <= busy_nxt;
            bus.done <= done_nxt;
            bus.word <= word_nxt;
`ifdef SCAN_PARITY_EN
            bus.parity <= parity_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CH_FIRST;
            WAIT:    if (bus.abort) state_nxt = IDLE;
                     else if (cnt <= 4'd1) state_nxt = SAMPLE;
            SAMPLE:  if (bus.abort) state_nxt = IDLE;
                     else if (bus.sel == 3'd7) state_nxt = DONE;
                     else state_nxt = CH_FIRST;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt    = cnt;
        shadow_nxt = shadow;
        sel_nxt    = bus.sel;
        busy_nxt   = bus.busy;
        done_nxt   = 1'b0;
        word_nxt   = bus.word;
`ifdef SCAN_PARITY_EN
        parity_nxt = bus.parity;
`endif
        case (state)
            IDLE: begin
                sel_nxt  = '0;
                busy_nxt = 1'b0;
                if (bus.start) begin
                    busy_nxt   = 1'b1;
                    cnt_nxt    = SETTLE_L;
                    shadow_nxt = '0;
                end
            end
            WAIT: begin
                if (bus.abort) begin
                    sel_nxt    = '0;
                    busy_nxt   = 1'b0;
                    cnt_nxt    = '0;
                    shadow_nxt = '0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            SAMPLE: begin
                // Abort wins over the capture so a cancelled scan leaves no trace.
                if (bus.abort) begin
                    sel_nxt    = '0;
                    busy_nxt   = 1'b0;
                    cnt_nxt    = '0;
                    shadow_nxt = '0;
                end else if (bus.sel != 3'd7) begin
                    shadow_nxt[bus.sel] = bus.mux_op;
                    sel_nxt             = bus.sel + 3'd1;
                    cnt_nxt             = SETTLE_L;
                end else begin
                    word_nxt = {bus.mux_op, shadow};
`ifdef SCAN_PARITY_EN
                    parity_nxt = ^{bus.mux_op, shadow};
`endif
                    sel_nxt  = '0;
                    busy_nxt = 1'b0;
                    done_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench: three sequencers with SETTLE 0, 1, 2, each fed by its own modelled 8:1 mux.
module tb_mux_scan_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_scan_if b0 ();
    mux_scan_if b1 ();
    mux_scan_if b2 ();
    logic [7:0] m0, m1, m2;
    assign b0.mux_op = m0[b0.sel];
    assign b1.mux_op = m1[b1.sel];
    assign b2.mux_op = m2[b2.sel];

    mux_scan_sequencer #(.SETTLE(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    mux_scan_sequencer #(.SETTLE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    mux_scan_sequencer #(.SETTLE(2)) u2 (.clk(clk), .rst(rst), .bus(b2));

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         dut;
        logic [7:0] m;
        logic [7:0] exp_word;
        int         exp_lat;
        logic       exp_par;
    } vec_t;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] rd_sel(int w);
        case (w) 0: return b0.sel; 1: return b1.sel; default: return b2.sel; endcase
    endfunction
    function automatic logic rd_busy(int w);
        case (w) 0: return b0.busy; 1: return b1.busy; default: return b2.busy; endcase
    endfunction
    function automatic logic rd_done(int w);
        case (w) 0: return b0.done; 1: return b1.done; default: return b2.done; endcase
    endfunction
    function automatic logic [7:0] rd_word(int w);
        case (w) 0: return b0.word; 1: return b1.word; default: return b2.word; endcase
    endfunction
`ifdef SCAN_PARITY_EN
    function automatic logic rd_par(int w);
        case (w) 0: return b0.parity; 1: return b1.parity; default: return b2.parity; endcase
    endfunction
`endif

    task automatic set_in(int w, logic st, logic ab, logic [7:0] m);
        case (w)
            0: begin b0.start = st; b0.abort = ab; m0 = m; end
            1: begin b1.start = st; b1.abort = ab; m1 = m; end
            default: begin b2.start = st; b2.abort = ab; m2 = m; end
        endcase
    endtask

    // One start pulse; sel/busy are checked every cycle, lat = edges from start edge to done.
    task automatic run_scan(int w, logic [7:0] m, output int lat);
        int exp_sel;
        @(negedge clk);
        set_in(w, 1'b1, 1'b0, m);
        @(posedge clk); #1;
        set_in(w, 1'b0, 1'b0, m);
        chk("start_sel", rd_sel(w), 0);
        chk("start_busy", rd_busy(w), 1);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            exp_sel = (k < 8 * (w + 1)) ? k / (w + 1) : 0;
            chk("scan_sel", rd_sel(w), exp_sel);
            if (rd_done(w)) begin
                lat = k;
                chk("busy_in_done", rd_busy(w), 0);
                break;
            end
            chk("scan_busy", rd_busy(w), 1);
        end
        @(posedge clk); #1;
        chk("done_fall", rd_done(w), 0);
    endtask

    initial begin
        vec_t vecs[6];
        int   lat;
        int   dtimes[3];
        int   nd;
        vecs[0] = '{1, 8'hA5, 8'hA5, 16, 1'b0};
        vecs[1] = '{0, 8'h01, 8'h01, 8,  1'b1};
        vecs[2] = '{2, 8'h5A, 8'h5A, 24, 1'b0};
        vecs[3] = '{0, 8'hFF, 8'hFF, 8,  1'b0};
        vecs[4] = '{1, 8'h80, 8'h80, 16, 1'b1};
        vecs[5] = '{1, 8'h3C, 8'h3C, 16, 1'b0};

        rst = 1'b1;
        for (int w = 0; w < 3; w++) set_in(w, 1'b0, 1'b0, 8'h00);
        #12;
        for (int w = 0; w < 3; w++) begin
            chk("rst_sel", rd_sel(w), 0);
            chk("rst_busy", rd_busy(w), 0);
            chk("rst_done", rd_done(w), 0);
            chk("rst_word", rd_word(w), 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_scan(vecs[i].dut, vecs[i].m, lat);
            chk("vec_lat", lat, vecs[i].exp_lat);
            chk("vec_word", rd_word(vecs[i].dut), vecs[i].exp_word);
`ifdef SCAN_PARITY_EN
            chk("vec_parity", rd_par(vecs[i].dut), vecs[i].exp_par);
`endif
        end

        // Abort at channel 5 of a second scan: word keeps 3C, no done.
        @(negedge clk);
        set_in(1, 1'b1, 1'b0, 8'hFF);
        @(posedge clk); #1;
        set_in(1, 1'b0, 1'b0, 8'hFF);
        for (int k = 0; k < 100 && rd_sel(1) != 3'd5; k++) begin
            @(posedge clk); #1;
        end
        chk("abort_reach_sel5", rd_sel(1), 5);
        @(negedge clk);
        set_in(1, 1'b0, 1'b1, 8'hFF);
        @(posedge clk); #1;
        set_in(1, 1'b0, 1'b0, 8'hFF);
        chk("abort_busy", rd_busy(1), 0);
        chk("abort_sel", rd_sel(1), 0);
        chk("abort_done", rd_done(1), 0);
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (rd_done(1)) nd++;
        end
        chk("abort_no_done", nd, 0);
        chk("abort_word", rd_word(1), 8'h3C);

        // start held high on SETTLE=2: done every 26 cycles, never busy in DONE.
        @(negedge clk);
        set_in(2, 1'b1, 1'b0, 8'hC3);
        @(posedge clk); #1;
        nd = 0;
        for (int t = 1; t <= 120 && nd < 3; t++) begin
            @(posedge clk); #1;
            if (rd_done(2)) begin
                chk("held_busy_in_done", rd_busy(2), 0);
                dtimes[nd] = t;
                nd++;
            end
        end
        chk("held_done_count", nd, 3);
        chk("held_first_done", dtimes[0], 24);
        chk("held_period1", dtimes[1] - dtimes[0], 26);
        chk("held_period2", dtimes[2] - dtimes[1], 26);
        chk("held_word", rd_word(2), 8'hC3);
        @(negedge clk);
        set_in(2, 1'b0, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("held_idle_busy", rd_busy(2), 0);

        // Channel 2 input wiggles during its WAIT cycles; only the sampling-edge value counts.
        @(negedge clk);
        set_in(2, 1'b1, 1'b0, 8'h00);
        @(posedge clk); #1;
        set_in(2, 1'b0, 1'b0, 8'h00);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            case (k)
                6: m2 = 8'h04;
                7: m2 = 8'h00;
                8: m2 = 8'h04;
                9: m2 = 8'h00;
                default: ;
            endcase
            if (rd_done(2)) begin
                lat = k;
                break;
            end
        end
        chk("settle_lat", lat, 24);
        chk("settle_word", rd_word(2), 8'h04);
`ifdef SCAN_PARITY_EN
        chk("settle_parity", rd_par(2), 1);
`endif

        // Asynchronous reset during channel 3, checked before any clock edge.
        @(negedge clk);
        set_in(1, 1'b1, 1'b0, 8'hFF);
        @(posedge clk); #1;
        set_in(1, 1'b0, 1'b0, 8'hFF);
        for (int k = 0; k < 100 && rd_sel(1) != 3'd3; k++) begin
            @(posedge clk); #1;
        end
        chk("rst_reach_sel3", rd_sel(1), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sel", rd_sel(1), 0);
        chk("arst_busy", rd_busy(1), 0);
        chk("arst_done", rd_done(1), 0);
        chk("arst_word1", rd_word(1), 8'h00);
        chk("arst_word2", rd_word(2), 8'h00);
`ifdef SCAN_PARITY_EN
        chk("arst_parity", rd_par(1), 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_scan(0, 8'h96, lat);
        chk("post_rst_lat", lat, 8);
        chk("post_rst_word", rd_word(0), 8'h96);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
